x_sequencer: RTL and testbench
==============================

X_SEQUENCER -- requirements
Module: x_sequencer

Interface
REQ-001 SHALL have port i_clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port i_host_valid  in  1  host command byte strobe from UART RX.
REQ-004 SHALL have port i_host_data  in  8  host command; [3:0] opcode, [7:4] argument.
REQ-005 SHALL have port o_cmd_valid  out  1  command strobe to the byte driver.
REQ-006 SHALL have port o_cmd_data  out  8  command byte to the byte driver.
REQ-007 SHALL have port i_tx_valid  in  1  driver output-byte-held flag.
REQ-008 SHALL have port i_tx_accept  in  1  UART TX has consumed the driver byte.
REQ-009 SHALL have port o_dl_launch  out  1  one-cycle delay-line start pulse.
REQ-010 SHALL have port i_dl_valid  in  1  delay-line result ready; a level held until the next o_dl_launch.
REQ-011 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port o_err  out  1  sticky timeout flag.
REQ-013 SHALL have port o_drop  out  1  one-cycle pulse when a host byte is discarded.

Function
REQ-014 SHALL register o_cmd_valid/o_cmd_data; every command appears exactly 1 cycle after its cause.
REQ-015 SHALL, in IDLE, forward host opcodes 0x0/0x1/0x2 unchanged (full byte) with 1-cycle latency.
REQ-016 SHALL treat host opcode 0x3 as START: burst of N samples, N = i_host_data[7:4], 0 meaning 16; forwards nothing; clears o_err.
REQ-017 SHALL treat host opcode 0x4 as ABORT: in any state, next state IDLE, sample counter cleared, no command issued.
REQ-018 SHALL ignore host opcodes 0x5-0xF with no drop pulse.
REQ-019 SHALL, when not IDLE, discard host opcodes 0x0-0x3 and pulse o_drop the following cycle.
REQ-020 SHALL implement states IDLE, LAUNCH, WAIT_DL, CAPTURE, UNLOAD, WAIT_TX.
REQ-021 LAUNCH: o_dl_launch high one cycle; clear 8-bit timeout counter; go WAIT_DL.
REQ-022 WAIT_DL: on i_dl_valid go CAPTURE; otherwise increment timeout; on reaching 255 without i_dl_valid, set o_err, skip sample (REQ-025 decision).
REQ-023 CAPTURE: issue command 0x02 for one cycle; clear 2-bit byte counter; go UNLOAD.
REQ-024 UNLOAD: issue command 0x01 for one cycle; go WAIT_TX; WAIT_TX leaves only on i_tx_valid & i_tx_accept, incrementing byte counter; after 4th byte go to REQ-025 decision, else UNLOAD.
REQ-025 Sample end: decrement remaining count; nonzero -> LAUNCH, zero -> IDLE.
REQ-026 i_tx_accept without i_tx_valid in WAIT_TX SHALL be ignored.
REQ-027 Simultaneous ABORT and any internal transition SHALL resolve to ABORT; a command scheduled that same cycle SHALL NOT be issued.
REQ-028 o_cmd_valid SHALL never be high in two consecutive cycles.
REQ-029 START received while busy SHALL be dropped per REQ-019; running burst unaffected.

Reset
REQ-030 While i_rst_n low: state IDLE; o_cmd_valid, o_cmd_data, o_dl_launch, o_busy, o_err, o_drop all 0; all counters 0.
REQ-031 Reset asserted mid-burst SHALL abort immediately with no further commands after release until a new START.

Verification
REQ-032 IDLE host 0xA0 -> next cycle o_cmd_valid=1, o_cmd_data=0xA0, o_busy=0.
REQ-033 Host 0x13, dl_valid 5 cycles after launch, accept 3 cycles after each tx_valid -> exactly one launch, one 0x02, four 0x01, then IDLE.
REQ-034 Host 0x03 (N=16) -> 16 o_dl_launch pulses, 64 0x01 commands, o_busy falls after final accept.
REQ-035 Host 0x23, i_dl_valid held low -> o_err=1 after 255 WAIT_DL cycles, second launch follows, o_err stays 1 until next START.
REQ-036 Host 0x00 during WAIT_TX -> o_drop pulse, no 0x00 command; then 0x04 -> IDLE next cycle, no further commands.
REQ-037 i_rst_n low during WAIT_DL -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/x_sequencer.sv
// x_sequencer: turns host command bytes into byte-driver commands and runs
// delay-line sample bursts (launch, wait for result, capture, unload 4 bytes).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | forward host opcodes 0x0-0x2, wait for START
// LAUNCH  | o_dl_launch is high this cycle, timeout counter cleared
// WAIT_DL | wait for the delay-line result or a 255-cycle timeout
// CAPTURE | issue 0x02 to the byte driver
// UNLOAD  | issue 0x01 once the command bus is free
// WAIT_TX | wait for the driver byte to be accepted by the UART TX
module x_sequencer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_host_valid,
    input  logic [7:0] i_host_data,
    output logic       o_cmd_valid,
    output logic [7:0] o_cmd_data,
    input  logic       i_tx_valid,
    input  logic       i_tx_accept,
    output logic       o_dl_launch,
    input  logic       i_dl_valid,
    output logic       o_busy,
    output logic       o_err,
    output logic       o_drop
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT_DL = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [7:0] CMD_CAPTURE  = 8'h02;
    localparam logic [7:0] CMD_UNLOAD   = 8'h01;
    // The increment out of this value is the 255th waiting cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;

    state_t     state;
    logic [4:0] remaining;
    logic [7:0] timeout;
    logic [1:0] byte_cnt;

    logic [3:0] opcode;
    logic [3:0] arg;
    logic       host_fwd;
    logic       host_start;
    logic       host_abort;
    logic [4:0] start_count;
    logic [4:0] remaining_dec;
    logic       more_samples;

    assign opcode        = i_host_data[3:0];
    assign arg           = i_host_data[7:4];
    assign host_fwd      = i_host_valid && (opcode <= 4'h2);
    assign host_start    = i_host_valid && (opcode == 4'h3);
    assign host_abort    = i_host_valid && (opcode == 4'h4);
    assign start_count   = (arg == 4'd0) ? 5'd16 : {1'b0, arg};
    assign remaining_dec = remaining - 5'd1;
    assign more_samples  = (remaining_dec != 5'd0);

    // Sequencer FSM with all outputs registered; ABORT overrides every transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            timeout     <= '0;
            byte_cnt    <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd_data  <= '0;
            o_dl_launch <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
            o_drop      <= 1'b0;
        end else begin
            o_cmd_valid <= 1'b0;
            o_dl_launch <= 1'b0;
            o_drop      <= 1'b0;
            if (host_abort) begin
                state     <= IDLE;
                remaining <= '0;
                timeout   <= '0;
                byte_cnt  <= '0;
                o_busy    <= 1'b0;
            end else begin
                if ((state != IDLE) && (host_fwd || host_start)) begin
                    o_drop <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (host_fwd) begin
                            // Back-to-back forwards would put two commands in a row on the bus.
                            if (o_cmd_valid) begin
                                o_drop <= 1'b1;
                            end else begin
                                o_cmd_valid <= 1'b1;
                                o_cmd_data  <= i_host_data;
                            end
                        end else if (host_start) begin
                            remaining   <= start_count;
                            o_err       <= 1'b0;
                            o_dl_launch <= 1'b1;
                            o_busy      <= 1'b1;
                            state       <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        timeout <= '0;
                        state   <= WAIT_DL;
                    end
                    WAIT_DL: begin
                        if (i_dl_valid) begin
                            state <= CAPTURE;
                        end else begin
                            timeout <= timeout + 8'd1;
                            if (timeout == TIMEOUT_LAST) begin
                                o_err       <= 1'b1;
                                remaining   <= remaining_dec;
                                o_dl_launch <= more_samples;
                                o_busy      <= more_samples;
                                state       <= more_samples ? LAUNCH : IDLE;
                            end
                        end
                    end
                    CAPTURE: begin
                        o_cmd_valid <= 1'b1;
                        o_cmd_data  <= CMD_CAPTURE;
                        byte_cnt    <= '0;
                        state       <= UNLOAD;
                    end
                    UNLOAD: begin
                        // CAPTURE's 0x02 is on the bus during the first UNLOAD cycle, so wait it out.
                        if (!o_cmd_valid) begin
                            o_cmd_valid <= 1'b1;
                            o_cmd_data  <= CMD_UNLOAD;
                            state       <= WAIT_TX;
                        end
                    end
                    WAIT_TX: begin
                        if (i_tx_valid && i_tx_accept) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                remaining   <= remaining_dec;
                                o_dl_launch <= more_samples;
                                o_busy      <= more_samples;
                                state       <= more_samples ? LAUNCH : IDLE;
                            end else begin
                                state <= UNLOAD;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_x_sequencer.sv
// tb_x_sequencer: randomized bench for x_sequencer with a burst-level model
// of the expected command stream, launches, drops and error flag.
`timescale 1ns/1ps
module tb_x_sequencer;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_host_valid;
    logic [7:0] i_host_data;
    logic       o_cmd_valid;
    logic [7:0] o_cmd_data;
    logic       i_tx_valid;
    logic       i_tx_accept;
    logic       o_dl_launch;
    logic       i_dl_valid;
    logic       o_busy;
    logic       o_err;
    logic       o_drop;

    x_sequencer dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_host_valid (i_host_valid),
        .i_host_data  (i_host_data),
        .o_cmd_valid  (o_cmd_valid),
        .o_cmd_data   (o_cmd_data),
        .i_tx_valid   (i_tx_valid),
        .i_tx_accept  (i_tx_accept),
        .o_dl_launch  (o_dl_launch),
        .i_dl_valid   (i_dl_valid),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_drop       (o_drop)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] got_cmds[$];
    int launch_cycs[$];
    int launch_total = 0;
    int drop_total = 0;
    int consec_total = 0;
    int err_rise_cyc = 0;

    int plan[16];
    int dl_seen = 0;
    int dl_base = 0;
    int tx_t1 = 0;
    int tx_t2 = -1;
    int last_acc_cyc = 0;
    int launch_base = 0;

    // Clock and free-running cycle counter.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: records commands, launches, drops and error-flag rises.
    initial begin
        logic prev_valid;
        logic prev_err;
        prev_valid = 1'b0;
        prev_err   = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_cmd_valid === 1'b1) begin
                got_cmds.push_back(o_cmd_data);
                if (prev_valid) consec_total++;
            end
            prev_valid = (o_cmd_valid === 1'b1);
            if (o_dl_launch === 1'b1) begin
                launch_total++;
                launch_cycs.push_back(cyc);
            end
            if (o_drop === 1'b1) drop_total++;
            if ((o_err === 1'b1) && !prev_err) err_rise_cyc = cyc;
            prev_err = (o_err === 1'b1);
        end
    end

    // Delay line: result level after plan[k] cycles (0 = never), cleared by each launch.
    initial begin
        int d;
        int idx;
        i_dl_valid = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_dl_launch === 1'b1) begin
                i_dl_valid = 1'b0;
                idx = dl_seen - dl_base;
                d = (idx >= 0 && idx < 16) ? plan[idx] : 1;
                dl_seen++;
                if (d != 0) begin
                    repeat (d) @(negedge i_clk);
                    i_dl_valid = 1'b1;
                end
            end
        end
    end

    // Byte driver + UART TX: hold flag after each 0x01, then accept; stray accepts before the flag.
    initial begin
        int t1;
        int t2;
        i_tx_valid  = 1'b0;
        i_tx_accept = 1'b0;
        forever begin
            @(negedge i_clk);
            if ((o_cmd_valid === 1'b1) && (o_cmd_data == 8'h01)) begin
                t1 = (tx_t1 > 0) ? tx_t1 : int'($urandom_range(4, 1));
                t2 = (tx_t2 >= 0) ? tx_t2 : int'($urandom_range(3, 0));
                for (int k = 0; k < t1; k++) begin
                    i_tx_accept = ($urandom_range(3) == 0);
                    @(negedge i_clk);
                end
                i_tx_accept = 1'b0;
                i_tx_valid  = 1'b1;
                repeat (t2) @(negedge i_clk);
                i_tx_accept = 1'b1;
                @(negedge i_clk);
                last_acc_cyc = cyc;
                i_tx_valid  = 1'b0;
                i_tx_accept = 1'b0;
            end
        end
    end

    task automatic send_host(input logic [7:0] b);
        @(negedge i_clk);
        i_host_valid = 1'b1;
        i_host_data  = b;
        @(negedge i_clk);
        i_host_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq({tag, "_cmd_valid"}, 32'(o_cmd_valid), 32'd0);
        expect_eq({tag, "_cmd_data"},  32'(o_cmd_data),  32'd0);
        expect_eq({tag, "_dl_launch"}, 32'(o_dl_launch), 32'd0);
        expect_eq({tag, "_busy"},      32'(o_busy),      32'd0);
        expect_eq({tag, "_err"},       32'(o_err),       32'd0);
        expect_eq({tag, "_drop"},      32'(o_drop),      32'd0);
    endtask

    // One START burst of the given argument against the per-sample plan.
    task automatic run_burst(input logic [3:0] arg, input bit inject);
        int n;
        int cmd_base;
        int drop_base;
        int exp_drops;
        int budget;
        int busy_fall;
        int got_n;
        logic [7:0] exp_cmds[$];
        logic exp_err;
        logic last_to;
        logic [3:0] op;
        n = (arg == 4'd0) ? 16 : int'(arg);
        exp_err = 1'b0;
        exp_drops = 0;
        for (int i = 0; i < n; i++) begin
            if (plan[i] == 0) begin
                exp_err = 1'b1;
            end else begin
                exp_cmds.push_back(8'h02);
                repeat (4) exp_cmds.push_back(8'h01);
            end
        end
        last_to     = (plan[n-1] == 0);
        cmd_base    = got_cmds.size();
        drop_base   = drop_total;
        launch_base = launch_total;
        dl_base     = dl_seen;
        send_host({arg, 4'h3});
        expect_eq("start_busy", 32'(o_busy), 32'd1);
        expect_eq("start_err_clear", 32'(o_err), 32'd0);
        expect_eq("start_no_cmd", 32'(o_cmd_valid), 32'd0);
        budget = 8000;
        busy_fall = -1;
        while (budget > 0) begin
            @(negedge i_clk);
            i_host_valid = 1'b0;
            if (o_busy !== 1'b1) begin
                busy_fall = cyc;
                break;
            end
            if (inject && ($urandom_range(7) == 0)) begin
                op = 4'($urandom_range(15));
                if (op == 4'h4) op = 4'h9;
                i_host_valid = 1'b1;
                i_host_data  = {4'($urandom_range(15)), op};
                if (op <= 4'h3) exp_drops++;
            end
            budget--;
        end
        i_host_valid = 1'b0;
        expect_eq("burst_done", 32'(o_busy), 32'd0);
        repeat (2) @(negedge i_clk);
        got_n = got_cmds.size() - cmd_base;
        expect_eq("cmd_count", 32'(got_n), 32'(exp_cmds.size()));
        for (int i = 0; i < got_n && i < exp_cmds.size(); i++) begin
            expect_eq($sformatf("cmd_byte[%0d]", i), 32'(got_cmds[cmd_base+i]), 32'(exp_cmds[i]));
        end
        expect_eq("launch_count", 32'(launch_total - launch_base), 32'(n));
        expect_eq("drop_count", 32'(drop_total - drop_base), 32'(exp_drops));
        expect_eq("err_flag", 32'(o_err), 32'(exp_err));
        expect_eq("no_b2b_cmd", 32'(consec_total), 32'd0);
        if (!last_to && busy_fall >= 0) begin
            expect_eq("busy_fall_cycle", 32'(busy_fall), 32'(last_acc_cyc));
        end
    endtask

    initial begin
        logic [7:0] b;
        int budget;
        int snap_cmds;
        int snap_launch;
        int snap_drop;
        bit found;

        i_rst_n      = 1'b0;
        i_host_valid = 1'b0;
        i_host_data  = 8'h00;
        for (int i = 0; i < 16; i++) plan[i] = 1;

        // Reset values.
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Forwarding of 0xA0 in IDLE.
        send_host(8'hA0);
        expect_eq("fwd_a0_valid", 32'(o_cmd_valid), 32'd1);
        expect_eq("fwd_a0_data", 32'(o_cmd_data), 32'hA0);
        expect_eq("fwd_a0_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        expect_eq("fwd_a0_one_cycle", 32'(o_cmd_valid), 32'd0);

        // Random IDLE bytes: 0x0-0x2 forwarded, ABORT and 0x5-0xF silent.
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(255));
            if (b[3:0] == 4'h3) b[3:0] = 4'h6;
            send_host(b);
            if (b[3:0] <= 4'h2) begin
                expect_eq("idle_fwd_valid", 32'(o_cmd_valid), 32'd1);
                expect_eq("idle_fwd_data", 32'(o_cmd_data), 32'(b));
            end else begin
                expect_eq("idle_ignore_valid", 32'(o_cmd_valid), 32'd0);
            end
            expect_eq("idle_no_drop", 32'(o_drop), 32'd0);
            expect_eq("idle_busy", 32'(o_busy), 32'd0);
            @(negedge i_clk);
        end

        // Single-sample burst, result after 5 cycles, accept 3 cycles after each flag.
        plan[0] = 5;
        tx_t1 = 2;
        tx_t2 = 3;
        run_burst(4'h1, 1'b0);

        // Full 16-sample burst.
        tx_t1 = 0;
        tx_t2 = -1;
        for (int i = 0; i < 16; i++) plan[i] = int'($urandom_range(20, 1));
        run_burst(4'h0, 1'b0);

        // Timeout on the first sample, second sample completes.
        plan[0] = 0;
        plan[1] = 5;
        run_burst(4'h2, 1'b0);
        if (launch_cycs.size() >= launch_base + 2) begin
            expect_eq("timeout_relaunch_gap", 32'(launch_cycs[launch_base+1] - launch_cycs[launch_base]), 32'd256);
            expect_eq("timeout_err_gap", 32'(err_rise_cyc - launch_cycs[launch_base]), 32'd256);
        end
        repeat (10) @(negedge i_clk);
        expect_eq("err_sticky", 32'(o_err), 32'd1);

        // Randomized bursts with host traffic while busy.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) begin
                plan[i] = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(20, 1));
            end
            run_burst(4'($urandom_range(15)), 1'b1);
            repeat (5) @(negedge i_clk);
        end

        // Host 0x00 in WAIT_TX is dropped, then ABORT returns to IDLE.
        plan[0] = 3;
        tx_t1 = 12;
        tx_t2 = 1;
        snap_cmds = got_cmds.size();
        snap_launch = launch_total;
        snap_drop = drop_total;
        dl_base = dl_seen;
        send_host(8'h13);
        found = 1'b0;
        budget = 200;
        while (budget > 0 && !found) begin
            @(negedge i_clk);
            if ((o_cmd_valid === 1'b1) && (o_cmd_data == 8'h01)) found = 1'b1;
            budget--;
        end
        expect_eq("reach_wait_tx", 32'(found), 32'd1);
        send_host(8'h00);
        expect_eq("busy_drop_pulse", 32'(o_drop), 32'd1);
        expect_eq("busy_drop_no_cmd", 32'(o_cmd_valid), 32'd0);
        @(negedge i_clk);
        expect_eq("drop_one_cycle", 32'(o_drop), 32'd0);
        send_host(8'h04);
        expect_eq("abort_idle", 32'(o_busy), 32'd0);
        repeat (40) @(negedge i_clk);
        expect_eq("abort_cmds", 32'(got_cmds.size() - snap_cmds), 32'd2);
        expect_eq("abort_launches", 32'(launch_total - snap_launch), 32'd1);
        expect_eq("abort_drops", 32'(drop_total - snap_drop), 32'd1);
        expect_eq("abort_still_idle", 32'(o_busy), 32'd0);
        tx_t1 = 0;
        tx_t2 = -1;

        // Reset asserted in WAIT_DL.
        plan[0] = 20;
        dl_base = dl_seen;
        send_host(8'h43);
        expect_eq("pre_reset_launch", 32'(o_dl_launch), 32'd1);
        repeat (3) @(negedge i_clk);
        expect_eq("pre_reset_busy", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        snap_cmds = got_cmds.size();
        snap_launch = launch_total;
        repeat (40) @(negedge i_clk);
        expect_eq("post_reset_cmds", 32'(got_cmds.size() - snap_cmds), 32'd0);
        expect_eq("post_reset_launches", 32'(launch_total - snap_launch), 32'd0);
        expect_eq("post_reset_busy", 32'(o_busy), 32'd0);

        // Recovery burst after reset.
        for (int i = 0; i < 16; i++) plan[i] = int'($urandom_range(20, 1));
        run_burst(4'($urandom_range(6, 1)), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
